pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/W registers).
//  - Drives stall/flush to every pipeline register and forwarding selects to the E-stage ALU.
//  - Holds the pipeline on multi-cycle data-memory accesses, with timeout.
//  - Counts stall cycles.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Forwarding select encodings, controller FSM states, E-stage load result code.
// Imported by fwd_unit and pipeline_hazard_ctrl.
package pipeline_ctrl_pkg;

    // E-stage ALU operand source
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,     // register file value from D/E register
        FWD_W  = 2'b01,     // ResultW
        FWD_M  = 2'b10      // ALUResultM
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    // ResultSrcE value that marks the E-stage instruction as a load
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding compare for one E-stage source operand.
// Latency: combinational, same cycle.
// Ports: rs (E source reg), reg_write_m/rd_m, reg_write_w/rd_w -> sel (M beats W, x0 never forwarded).
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       reg_write_m,
    input  logic [4:0] rd_m,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        // M holds the younger producer, so it must win over W
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall/flush per
// pipeline register, E-stage forwarding selects, data-memory wait with timeout.
// Latency: stall/flush/forward outputs combinational; MemBusyM, MemErr, StallCount registered.
// Ports: Rs*/Rd*/ResultSrcE/RegWrite*/PCSrcE/MemReqM/MemReadyM in; Stall*/Flush*/Forward*E,
//        MemBusyM, MemErr (sticky until rst), StallCount (saturating) out.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemBusyM,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    // wait_cnt never exceeds MEM_TIMEOUT-1
    localparam int              WC_W         = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] TIMEOUT_LAST = WC_W'(MEM_TIMEOUT - 1);

    ctrl_state_t     state;
    logic [WC_W-1:0] wait_cnt;
    logic            timeout_now;
    logic            memstall;
    logic            lw_stall;
    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;

    fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .reg_write_m (RegWriteM),
        .rd_m        (RdM),
        .reg_write_w (RegWriteW),
        .rd_w        (RdW),
        .sel         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .reg_write_m (RegWriteM),
        .rd_m        (RdM),
        .reg_write_w (RegWriteW),
        .rd_w        (RdW),
        .sel         (fwd_b)
    );

    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // On the last permitted wait cycle the hold is dropped so the access is abandoned
    assign timeout_now = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_LAST);
    assign memstall    = MemReqM && !MemReadyM && !timeout_now;
    assign lw_stall    = (ResultSrcE == RESULT_SRC_MEM) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (memstall) begin
            // Whole pipe frozen; a taken branch in E stays put and resolves after release.
            // W gets a bubble so the held M instruction is not retired twice.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            // The load-using instruction in D is on the wrong path, so squash instead of stall
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memstall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!MemReqM || MemReadyM) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (timeout_now) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        MemErr   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign MemBusyM = (state == MEM_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if (StallF && !(&StallCount)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand-written
// memory-wait / timeout / reset-mid-wait sequences, then randomized run against a model.
module tb_pipeline_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MemBusyM, MemErr;
    logic [CW-1:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemBusyM(MemBusyM), .MemErr(MemErr), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rse;
        logic       rwm, rww, pc;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Packed view of the stall/flush/forward group: {SF,SD,SE,SM,FD,FE,FW,FA,FB}
    function automatic logic [10:0] ctrl_vec();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
    endfunction

    // Reference forwarding choice: newest writer of the register wins, x0 never forwarded
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic rwm, input logic [4:0] rdm,
                                           input logic rww, input logic [4:0] rdw);
        if (rs == 0) return 2'b00;
        if (rwm && rdm == rs) return 2'b10;
        if (rww && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    int         exp_cnt;
    int         ep;        // consecutive cycles the current memory access has been held
    logic       m_err;
    logic       r_rst, r_ms, r_to, r_lw, r_sf;
    logic [10:0] r_vec;

    initial begin
        rst = 1'b1;
        clear_inputs();

        //            rs1d rs2d rs1e rs2e rde rdm rdw  rse  rwm rww pc   fa     fb    sf sd fd fe
        vecs[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0};
        vecs[1] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0};
        vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        vecs[3] = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0};
        vecs[4] = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1};
        vecs[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        vecs[6] = '{5'd7, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1};
        vecs[7] = '{5'd4, 5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1};
        vecs[8] = '{5'd7, 5'd0, 5'd6, 5'd6, 5'd7, 5'd6, 5'd0, 2'b10, 1, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0};

        // Reset state, observed while rst is held
        next_cycle();
        @(negedge clk);
        chk("rst_ctrl", 32'(ctrl_vec()), 32'(11'b0000_111_00_00));
        chk("rst_busy_err", 32'({MemBusyM, MemErr}), 32'd0);
        chk("rst_count", 32'(StallCount), 32'd0);
        do_reset();

        // Directed combinational vectors
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].rse;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pc;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(ctrl_vec()),
                32'({vecs[i].sf, vecs[i].sd, 1'b0, 1'b0, vecs[i].fd, vecs[i].fe, 1'b0, vecs[i].fa, vecs[i].fb}));
            if (vecs[i].sf) exp_cnt++;
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("vec_count", 32'(StallCount), 32'(exp_cnt));

        // Memory wait: not ready for 3 cycles, ready on the 4th
        do_reset();
        for (int i = 0; i < 4; i++) begin
            MemReqM = 1'b1;
            MemReadyM = (i == 3);
            PCSrcE = 1'b1;   // frozen while held, acts on the release cycle
            @(negedge clk);
            if (i < 3) chk($sformatf("mw_ctrl%0d", i), 32'(ctrl_vec()), 32'(11'b1111_001_00_00));
            else       chk("mw_release", 32'(ctrl_vec()), 32'(11'b0000_110_00_00));
            chk($sformatf("mw_busy%0d", i), 32'(MemBusyM), 32'(i >= 1));
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("mw_count", 32'(StallCount), 32'd3);
        chk("mw_idle", 32'({MemBusyM, MemErr}), 32'd0);

        // Timeout with MEM_TIMEOUT=4: held cycles 0..2, abandoned on cycle 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            MemReqM = 1'b1;
            MemReadyM = 1'b0;
            @(negedge clk);
            if (i <= 3) chk($sformatf("to_stall%0d", i), 32'(StallF), 32'(i < 3));
            chk($sformatf("to_err%0d", i), 32'(MemErr), 32'(i >= 4));
            next_cycle();
        end
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chk("to_err_sticky", 32'(MemErr), 32'd1);

        // Reset asserted in the middle of a wait
        do_reset();
        MemReqM = 1'b1;
        MemReadyM = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rstmid_ctrl", 32'(ctrl_vec()), 32'(11'b0000_111_00_00));
        chk("rstmid_state", 32'({MemBusyM, MemErr, StallCount}), 32'd0);
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chk("rstmid_after", 32'({MemBusyM, MemErr}), 32'd0);

        // Randomized run against the reference model
        do_reset();
        ep = 0; m_err = 1'b0; exp_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 399) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            MemReqM    = (ep != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            MemReadyM  = ($urandom_range(0, 3) == 0);

            r_rst = rst;
            r_to  = !r_rst && MemReqM && !MemReadyM && (ep == T - 1);
            r_ms  = !r_rst && MemReqM && !MemReadyM && !r_to;
            r_lw  = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
            r_sf  = 1'b0;
            if (r_rst)                     r_vec = 11'b0000_111_00_00;
            else if (r_ms)                 r_vec = 11'b1111_001_00_00;
            else if (PCSrcE)               r_vec = 11'b0000_110_00_00;
            else if (r_lw)                 r_vec = 11'b1100_010_00_00;
            else                           r_vec = 11'b0;
            r_sf = r_vec[10];
            if (!r_rst) begin
                r_vec[3:2] = ref_fwd(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
                r_vec[1:0] = ref_fwd(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            end
            if (r_rst) begin
                ep = 0; m_err = 1'b0; exp_cnt = 0;
            end

            @(negedge clk);
            chk($sformatf("rnd_ctrl%0d", c), 32'(ctrl_vec()), 32'(r_vec));
            chk($sformatf("rnd_state%0d", c), 32'({MemBusyM, MemErr, StallCount}),
                32'({(ep != 0), m_err, CW'(exp_cnt)}));

            // Effect of the coming clock edge
            if (!r_rst) begin
                ep = r_ms ? ep + 1 : 0;
                if (r_to) m_err = 1'b1;
                if (r_sf && exp_cnt < (1 << CW) - 1) exp_cnt++;
            end
            next_cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
